// File: rtl/lpc_cycle_dispatcher.sv
// LPC cycle dispatcher: edge-detects decoded LPC cycle records, filters them
// by address window and cycle type, buffers accepted records in a small FIFO
// and hands them to a single valid/ready consumer. The LPC side cannot be
// stalled, so records arriving at a full FIFO are dropped and counted.
module lpc_cycle_dispatcher #(
  parameter int          DEPTH         = 8,
  parameter logic [15:0] ADDR_LO       = 16'h0080,
  parameter logic [15:0] ADDR_HI       = 16'h0080,
  parameter bit          CAPTURE_READS = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic [31:0]              tdata_i,
  input  logic                     ready_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  output logic [31:0]              m_tdata_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  // Cycle type accepted for capture: writes always, reads when enabled.
  function automatic logic type_ok(input logic [1:0] t);
    return (t == 2'b01) || ((t == 2'b11) && CAPTURE_READS);
  endfunction

  // Saturating increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              ready_q;
  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [15:0]       rec_addr;
  logic [1:0]        rec_type;
  logic              cap_evt;
  logic              in_window;
  logic              accept;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign rec_addr  = tdata_i[27:12];
  assign rec_type  = tdata_i[1:0];
  assign cap_evt   = ready_i & ~ready_q;
  assign in_window = (rec_addr >= ADDR_LO) && (rec_addr <= ADDR_HI);
  assign accept    = cap_evt & en_i & type_ok(rec_type) & in_window;
  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  // The output stage takes the head whenever it is free or being drained.
  assign pop       = ~empty & (~m_tvalid_o | m_tready_i);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push      = accept & (~full | pop);
  assign drop      = accept & full & ~pop;

  assign level_o   = level;

  // READY delay flop; resets high so a READY already asserted at reset
  // release is not mistaken for a new record. Tracks through clear.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) ready_q <= 1'b1;
    else         ready_q <= ready_i;
  end

  // Record storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem[wr_ptr] <= tdata_i;
  end

  // FIFO pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Output register stage: load from the head, release after the last beat.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
    end else if (clr_i) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
    end else if (pop) begin
      m_tvalid_o <= 1'b1;
      m_tdata_o  <= mem[rd_ptr];
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

  // Overflow statistics: sticky flag and saturating drop count.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clr_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      drop_cnt_o <= sat_inc16(drop_cnt_o);
    end
  end

endmodule
